// File: rtl/encode83_event.sv
// ============================================================================
// encode83_event
// ----------------------------------------------------------------------------
// Debounced, registered 8-to-3 priority encoder with a valid/ack event
// handshake. Eight raw request lines are synchronized and debounced. Each
// stable, non-zero pattern produces exactly one event carrying the index of
// the highest set line (bit 7 wins). A pending event is held until the
// consumer acknowledges it. If a new event arrives while one is still
// pending, the new event is dropped and a sticky overrun flag is raised.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive identical synchronized samples needed to
//                    accept a pattern (legal range 2..255, 8-bit counter)
//
// Ports
//   clk        in   rising-edge clock for all logic
//   rst_n      in   synchronous active-low reset
//   Din[7:0]   in   raw asynchronous request lines, bit 7 highest priority
//   Dout[2:0]  out  index of the highest set bit of the accepted pattern
//   multi      out  accepted pattern had more than one bit set
//   evt_valid  out  an event is pending; Dout/multi valid while high
//   evt_ack    in   consumer accepts the pending event
//   overrun    out  sticky: an event was dropped while one was pending
//   ovr_clr    in   clears overrun (a simultaneous overrun wins)
//   busy       out  registered, high while the FSM is away from IDLE
// ============================================================================
module encode83_event #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Din,
    output logic [2:0] Dout,
    output logic       multi,
    output logic       evt_valid,
    input  logic       evt_ack,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Counter value on which the final confirming sample is seen. The counter
    // is loaded with 1 on the first sample of a new pattern, so reaching
    // DEBOUNCE_CYCLES-1 with one more matching sample makes DEBOUNCE_CYCLES.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Signal declarations
    // ------------------------------------------------------------------------
    logic [7:0] sync1_q;
    logic [7:0] din_s_q;

    logic [1:0] state_q, state_d;
    logic [7:0] cand_q,  cand_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       emit;

    logic [2:0] emit_code;
    logic       emit_multi;

    logic [2:0] dout_q,      dout_d;
    logic       multi_q,     multi_d;
    logic       evt_valid_q, evt_valid_d;
    logic       overrun_q,   overrun_d;
    logic       busy_q,      busy_d;

    // ------------------------------------------------------------------------
    // Encoding helpers
    // ------------------------------------------------------------------------

    // Index of the highest set bit; scanning upward lets later (higher)
    // bits overwrite lower ones, giving bit 7 the top priority.
    function automatic logic [2:0] highest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // More than one bit set: clearing the lowest set bit (v & (v-1)) leaves
    // something behind only if a second bit was present.
    function automatic logic has_multiple(input logic [7:0] v);
        return ((v & (v - 8'd1)) != 8'd0);
    endfunction

    // The event payload always comes from the candidate, because an emit
    // only happens on a sample that matches it.
    always_comb begin
        emit_code  = highest_index(cand_q);
        emit_multi = has_multiple(cand_q);
    end

    // ------------------------------------------------------------------------
    // Input synchronizer: two flops bring the raw lines into the clock domain
    // before any decision is made on them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 8'd0;
            din_s_q <= 8'd0;
        end else begin
            sync1_q <= Din;
            din_s_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce FSM
    //   IDLE     : nothing pressed, waiting for a non-zero sample
    //   DEBOUNCE : a candidate pattern is being counted toward acceptance
    //   HELD     : the candidate was accepted (event emitted), still pressed
    //   RELEASE  : zeros are being counted; a return of the same pattern is
    //              treated as release bounce and goes back to HELD silently
    // Any new non-zero pattern restarts the debounce with that pattern, so a
    // changed pattern always produces its own event once stable.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (din_s_q != 8'd0) begin
                    cand_d  = din_s_q;
                    cnt_d   = 8'd1;
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (din_s_q == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        emit    = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (din_s_q == 8'd0) begin
                    cand_d  = 8'd0;
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cand_d = din_s_q;
                    cnt_d  = 8'd1;
                end
            end

            ST_HELD: begin
                if (din_s_q == 8'd0) begin
                    cnt_d   = 8'd1;
                    state_d = ST_RELEASE;
                end else if (din_s_q != cand_q) begin
                    cand_d  = din_s_q;
                    cnt_d   = 8'd1;
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_RELEASE: begin
                if (din_s_q == 8'd0) begin
                    if (cnt_q == CNT_LAST) begin
                        cand_d  = 8'd0;
                        cnt_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (din_s_q == cand_q) begin
                    state_d = ST_HELD;
                end else begin
                    cand_d  = din_s_q;
                    cnt_d   = 8'd1;
                    state_d = ST_DEBOUNCE;
                end
            end

            default: begin
                cand_d  = 8'd0;
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Event handshake
    // An emit coinciding with an ack replaces the pending event cleanly: the
    // consumer has taken the old one, so nothing is lost and overrun stays
    // put. Only an emit against an unacknowledged event is dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        dout_d      = dout_q;
        multi_d     = multi_q;
        evt_valid_d = evt_valid_q;
        overrun_d   = overrun_q;

        if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        if (emit) begin
            if (!evt_valid_q || evt_ack) begin
                dout_d      = emit_code;
                multi_d     = emit_multi;
                evt_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (evt_ack && evt_valid_q) begin
            evt_valid_d = 1'b0;
        end
    end

    // busy follows the next state so the flop reads "not in IDLE" on the
    // same edge the FSM changes.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cand_q      <= 8'd0;
            cnt_q       <= 8'd0;
            dout_q      <= 3'd0;
            multi_q     <= 1'b0;
            evt_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            multi_q     <= multi_d;
            evt_valid_q <= evt_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all straight from flops
    // ------------------------------------------------------------------------
    assign Dout      = dout_q;
    assign multi     = multi_q;
    assign evt_valid = evt_valid_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: doc/encode83_event.md
# encode83_event

Debounced, registered 8-to-3 priority encoder with a valid/ack event handshake. It is the inverse of the team's 3-to-8 one-hot line decoder. It takes eight raw active-high request lines (keys or one-hot status lines) and synchronizes and debounces them. Each stable, non-zero pattern becomes exactly one event carrying the 3-bit index of the highest active line. The event is held until the consumer acknowledges it.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: number of consecutive identical synchronized samples required to accept a pattern. Legal range is 2..255; the counter is 8 bits.

Ports:
- clk, input, 1: single clock. All logic is on its rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- Din, input, 8: raw asynchronous request lines. Bit 7 has the highest priority.
- Dout, output, 3: encoded index of the highest set bit of the accepted pattern.
- multi, output, 1: high when the accepted pattern had more than one bit set.
- evt_valid, output, 1: an event is pending. Dout and multi are valid while it is high.
- evt_ack, input, 1: consumer accepts the pending event.
- overrun, output, 1: sticky flag, set when an event was dropped because the previous one was unacknowledged.
- ovr_clr, input, 1: clears overrun.
- busy, output, 1: high when the FSM is not in IDLE.

## Operation
- Din passes through a 2-flop synchronizer to give Din_s. Its reset value is 0.
- The FSM holds a candidate register cand[7:0] and a counter cnt[7:0].
- IDLE:
  - Din_s != 0: cand<=Din_s, cnt<=1, go to DEBOUNCE.
- DEBOUNCE:
  - Din_s==cand and cnt==DEBOUNCE_CYCLES-1: emit event, go to HELD.
  - Din_s==cand otherwise: cnt++.
  - Din_s==0: go to IDLE and discard cand.
  - Din_s is any other non-zero value: cand<=Din_s, cnt<=1, stay in DEBOUNCE.
- HELD:
  - Din_s==cand: stay.
  - Din_s==0: cnt<=1, go to RELEASE.
  - Other non-zero value: recapture cand, cnt<=1, go to DEBOUNCE. A new event follows if that pattern proves stable.
- RELEASE:
  - Din_s==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - Din_s==0 otherwise: cnt++.
  - Din_s==cand: go to HELD with no new event. This filters release bounce.
  - Other non-zero value: recapture, go to DEBOUNCE.
- Emit:
  - code = index of the highest set bit of cand.
  - multi = (popcount(cand) > 1).
- Handshake:
  - Emit while evt_valid=0: load Dout and multi, set evt_valid<=1.
  - evt_ack=1 while evt_valid=1 with no emit: evt_valid<=0. Dout and multi keep their last values.
  - Emit and evt_ack in the same cycle: the new event is loaded, evt_valid stays 1, overrun is not set.
  - Emit while evt_valid=1 and evt_ack=0: the new event is discarded, Dout and multi are unchanged, overrun<=1.
  - evt_ack while evt_valid=0 is ignored.
- overrun:
  - Cleared by ovr_clr.
  - If ovr_clr and an overrun condition occur in the same cycle, set wins.

## Timing
- Reset, when rst_n=0 at a rising edge:
  - Dout=0, multi=0, evt_valid=0, overrun=0, busy=0.
  - Synchronizer, cand and cnt are cleared; the FSM goes to IDLE.
- Reset mid-operation aborts any debounce or hold with no event. An input still asserted after reset yields a fresh event after the full latency.
- Press latency: let edge 1 be the first rising edge that samples a new stable Din.
  - evt_valid is high after edge DEBOUNCE_CYCLES+2; with the default this is edge 6.
- Release: Din must read 0 for DEBOUNCE_CYCLES synchronized samples before the FSM returns to IDLE.
  - A re-press of the same pattern only emits a new event after IDLE has been reached.
- busy is registered and is high from the cycle after IDLE is left until IDLE is re-entered.
- evt_valid falls on the edge that samples evt_ack=1. Minimum event occupancy is 1 cycle.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with Din=8'hFF. All outputs are 0. Release reset: evt_valid rises on edge 6, Dout=7, multi=1.
- Single press: Din=8'h04 held for 10 cycles. evt_valid rises 6 edges after the first sample, Dout=2, multi=0. Exactly one event occurs; pulse evt_ack and evt_valid drops on the next edge.
- Bounce: Din toggles 8'h10/8'h00 every 2 cycles for 8 cycles, then holds 8'h10. No event during the toggling; one event with Dout=4 once the value is held.
- Release bounce: after a held event on 8'h01, Din goes 0 for 2 cycles, back to 1 for 1 cycle, then 0 for 10 cycles. No second event; busy falls once 0 has been stable for 4 samples.
- Overrun: press 8'h20 with no ack, release fully, press 8'h02. overrun=1, Dout stays 5. ovr_clr clears overrun; evt_ack clears evt_valid.
- Simultaneous ack and emit: assert evt_ack on exactly the emit edge of a second event 8'h80. evt_valid stays 1, Dout=7, overrun stays 0.
